uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//  Parametrised UART transmit datapath for the next-gen uart_top. It sits between the APB register file
//  (THR writes, LCR/FCR/MCR/MGMT fields) and the txd pin. It provides a depth-parametrised TX FIFO and
//  5-8 bit frames with none/odd/even/stick parity and 1/1.5/2 stop bits. Oversampling is selectable
//  (16x/13x), and it supports break, loopback tap and THRE/TEMT status.
// PARAMETERS
//  FIFO_DEPTH  16  TX FIFO entries; power of 2, >=2
//  OSR_STD     16  bclk ticks per bit when osm_sel_in=0
//  OSR_ALT     13  bclk ticks per bit when osm_sel_in=1
//  LVL_W       $clog2(FIFO_DEPTH)+1  width of fifo_level_out (derived, localparam)
// PORTS
//  apb_clk_in      in   1      sole clock
//  apb_rstn_in     in   1      asynchronous active-low reset
//  bclk_tick_in    in   1      1-cycle oversample tick from the baud generator
//  thr_wr_in       in   1      push thr_data_in into FIFO (1-cycle pulse)
//  thr_data_in     in   8      byte to send; bits above word length ignored
//  fifo_en_in      in   1      1: FIFO_DEPTH deep; 0: single holding register
//  txclr_in        in   1      pulse: flush FIFO
//  utrst_in        in   1      0: transmitter held in reset; 1: enabled
//  wls_in          in   2      00=5, 01=6, 10=7, 11=8 data bits
//  stb_in          in   1      0: 1 stop; 1: 2 stop (1.5 when 5-bit)
//  pen_in,eps_in,sp_in in 1 each  parity enable / even select / stick
//  bc_in           in   1      break control
//  osm_sel_in      in   1      oversample select
//  loop_in         in   1      loopback: pin idles, serial routed to loop_txd_out
//  txd_out         out  1      serial pin
//  loop_txd_out    out  1      internal serial for rx loopback
//  thre_out        out  1      FIFO/holding register empty
//  temt_out        out  1      FIFO empty and shifter idle
//  fifo_level_out  out  LVL_W  current FIFO occupancy
//  tx_ovf_out      out  1      1-cycle pulse: write dropped because full
// BEHAVIOUR
//  Reset (rstn low, async): state IDLE, FIFO empty, txd_out=1, loop_txd_out=1, thre_out=1,
//    temt_out=1, fifo_level_out=0, tx_ovf_out=0. All outputs are registered.
//  FIFO: effective depth is FIFO_DEPTH when fifo_en_in=1, else 1.
//    Write when full: data dropped, tx_ovf_out pulses the next cycle.
//    Write and pop in the same cycle while full: both succeed.
//    Any change of fifo_en_in flushes the FIFO.
//    txclr_in: pointers and level go to 0 next cycle. A coincident write is dropped with no ovf.
//    txclr_in never aborts the frame in the shifter.
//  utrst_in=0: FSM forced to IDLE, FIFO flushed, writes ignored, txd=1. Config regs are untouched.
//  FSM IDLE->START->DATA->PARITY->STOP->IDLE (PARITY skipped when pen=0).
//    IDLE: if level>0 and utrst_in=1, pop into the shifter, clear the tick counter, go to START.
//      Serial line is 0 from the next cycle.
//    wls, stb, pen, eps, sp and osm_sel are latched at the pop and held for the whole frame.
//    Each bit lasts OSR ticks (OSR = latched OSR_STD or OSR_ALT), counted on bclk_tick_in.
//      The start bit may exceed OSR ticks by <1 tick period (alignment).
//    DATA: LSB first, N=wls+5 bits.
//    PARITY: pen=1, sp=0: XOR of data bits, XOR ~eps (eps=1 even, eps=0 odd).
//      pen=1, sp=1: parity bit = ~eps.
//    STOP: line 1 for OSR ticks (stb=0); 2*OSR (stb=1, N>5); OSR+floor(OSR/2) (stb=1, N=5).
//    After STOP: pop the next byte the same cycle if level>0 (back-to-back, no idle gap), else IDLE.
//  Serial select: loop_in=0: txd_out=serial, loop_txd_out=1.
//    loop_in=1: txd_out=1, loop_txd_out=serial.
//  bc_in=1 forces the active output to 0; FSM timing continues unaffected.
//  thre_out = (level==0). temt_out = (level==0) and state==IDLE.
//  Status updates one cycle after the causing event.
//  fifo_level_out never exceeds the effective depth.
// TESTING
//  1. 8N1, OSR16, tick every cycle, write 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1.
//     Each bit 16 cycles; temt_out=1 after stop.
//  2. 7E1, write 0x35 -> 7 data bits 1,0,1,0,1,1,0, parity 0, stop 1. Stick parity eps=1 -> parity 0.
//  3. Ticks held 0, fifo_en=1, 18 writes -> first byte in shifter, level=16.
//     18th write: tx_ovf_out pulses once, level stays 16.
//  4. wls=00, stb=1, osm_sel=1 -> stop lasts 19 ticks. fifo_en=0: 2nd write while thre=0 -> overflow.
//  5. apb_rstn_in low mid-DATA -> txd_out=1 immediately, level=0, thre=temt=1.
//     txclr mid-frame -> frame completes, level=0.
//  6. bc_in=1 mid-frame -> txd_out=0 until release, then frame resumes at correct bit position.
//     loop_in=1 -> txd_out=1, loop_txd_out carries the frame.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit datapath: TX FIFO feeding a 5-8 bit framer with parity, 1/1.5/2 stop, 16x/13x oversample, break and loopback.
// Latency: THR write to start bit on the line is 2 cycles, all outputs registered; backpressure: none, a write to a full FIFO is dropped and pulses tx_ovf_out.
module uart_tx_engine #(
    parameter int FIFO_DEPTH = 16,
    parameter int OSR_STD    = 16,
    parameter int OSR_ALT    = 13
) (
    input  logic                        apb_clk_in,
    input  logic                        apb_rstn_in,
    input  logic                        bclk_tick_in,
    input  logic                        thr_wr_in,
    input  logic [7:0]                  thr_data_in,
    input  logic                        fifo_en_in,
    input  logic                        txclr_in,
    input  logic                        utrst_in,
    input  logic [1:0]                  wls_in,
    input  logic                        stb_in,
    input  logic                        pen_in,
    input  logic                        eps_in,
    input  logic                        sp_in,
    input  logic                        bc_in,
    input  logic                        osm_sel_in,
    input  logic                        loop_in,
    output logic                        txd_out,
    output logic                        loop_txd_out,
    output logic                        thre_out,
    output logic                        temt_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_out,
    output logic                        tx_ovf_out
);
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OSR_MAX = (OSR_STD > OSR_ALT) ? OSR_STD : OSR_ALT;
    localparam int CNT_W   = $clog2(2 * OSR_MAX + 1);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] OSR_STD_C = CNT_W'(OSR_STD);
    localparam logic [CNT_W-1:0] OSR_ALT_C = CNT_W'(OSR_ALT);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             fifo_en_prev_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             par_q, par_d;
    logic [1:0]       wls_q, wls_d;
    logic             stb_q, stb_d, pen_q, pen_d, osm_q, osm_d;
    logic             txd_q, txd_d, loop_q, loop_d;
    logic             thre_q, thre_d, temt_q, temt_d, ovf_q, ovf_d;
    logic             flush, full, push, pop, start_frame, bit_end, ser, active;
    logic [CNT_W-1:0] osr, bit_lim;
    logic [7:0]       pop_dat, pop_mask;

    // FIFO bookkeeping; a pop frees the slot a same-cycle write needs, so full+pop accepts the write
    always_comb begin
        flush    = txclr_in | ~utrst_in | (fifo_en_in != fifo_en_prev_q);
        full     = fifo_en_in ? (level_q == DEPTH_LVL) : (level_q != '0);
        push     = 1'b0;
        ovf_d    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (thr_wr_in) begin
                if (full && !pop) ovf_d = 1'b1;
                else              push  = 1'b1;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_comb begin
        osr     = osm_q ? OSR_ALT_C : OSR_STD_C;
        bit_lim = osr;
        if (state_q == S_STOP && stb_q)
            bit_lim = (wls_q == 2'b00) ? (osr + (osr >> 1)) : (osr << 1);
        bit_end  = bclk_tick_in && (cnt_q == bit_lim - CNT_W'(1));
        pop_dat  = mem_q[rd_ptr_q];
        pop_mask = 8'hFF >> (2'd3 - wls_in);

        start_frame = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        wls_d   = wls_q;
        stb_d   = stb_q;
        pen_d   = pen_q;
        osm_d   = osm_q;

        if (bclk_tick_in && state_q != S_IDLE)
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE:   start_frame = (level_q != '0);
            S_START:  if (bit_end) begin
                          state_d = S_DATA;
                          bit_d   = '0;
                      end
            S_DATA:   if (bit_end) begin
                          sh_d = sh_q >> 1;
                          // last data bit index is wls+4
                          if (bit_q == {1'b1, wls_q}) state_d = pen_q ? S_PARITY : S_STOP;
                          else                        bit_d   = bit_q + 3'd1;
                      end
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP:   if (bit_end) begin
                          state_d     = S_IDLE;
                          start_frame = (level_q != '0);
                      end
            default:  state_d = S_IDLE;
        endcase

        if (!utrst_in) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            start_frame = 1'b0;
        end

        pop = start_frame;
        if (start_frame) begin
            state_d = S_START;
            cnt_d   = '0;
            bit_d   = '0;
            sh_d    = pop_dat;
            wls_d   = wls_in;
            stb_d   = stb_in;
            pen_d   = pen_in;
            osm_d   = osm_sel_in;
            par_d   = sp_in ? ~eps_in : ((^(pop_dat & pop_mask)) ^ ~eps_in);
        end

        case (state_d)
            S_START:  ser = 1'b0;
            S_DATA:   ser = sh_d[0];
            S_PARITY: ser = par_d;
            default:  ser = 1'b1;
        endcase
        active = utrst_in ? (ser & ~bc_in) : 1'b1;
        txd_d  = loop_in ? 1'b1 : active;
        loop_d = loop_in ? active : 1'b1;
    end

    always_comb begin
        thre_d = (level_d == '0);
        temt_d = (level_d == '0) && (state_d == S_IDLE);
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            fifo_en_prev_q <= 1'b1;
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            bit_q          <= '0;
            sh_q           <= '0;
            par_q          <= 1'b0;
            wls_q          <= 2'b11;
            stb_q          <= 1'b0;
            pen_q          <= 1'b0;
            osm_q          <= 1'b0;
            txd_q          <= 1'b1;
            loop_q         <= 1'b1;
            thre_q         <= 1'b1;
            temt_q         <= 1'b1;
            ovf_q          <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            fifo_en_prev_q <= fifo_en_in;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_q          <= bit_d;
            sh_q           <= sh_d;
            par_q          <= par_d;
            wls_q          <= wls_d;
            stb_q          <= stb_d;
            pen_q          <= pen_d;
            osm_q          <= osm_d;
            txd_q          <= txd_d;
            loop_q         <= loop_d;
            thre_q         <= thre_d;
            temt_q         <= temt_d;
            ovf_q          <= ovf_d;
        end
    end

    always_ff @(posedge apb_clk_in) begin
        if (push) mem_q[wr_ptr_q] <= thr_data_in;
    end

    assign txd_out        = txd_q;
    assign loop_txd_out   = loop_q;
    assign thre_out       = thre_q;
    assign temt_out       = temt_q;
    assign fifo_level_out = level_q;
    assign tx_ovf_out     = ovf_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: frame shapes, FIFO depth/overflow, flush, reset, break and loopback.
`timescale 1ns/1ps
module tb_uart_tx_engine;
    logic       clk = 1'b0;
    logic       rstn, tick, wr, fifo_en, txclr, utrst;
    logic [7:0] wdat;
    logic [1:0] wls;
    logic       stb, pen, eps, sp, bc, osm, loop;
    logic       txd, loop_txd, thre, temt, ovf;
    logic [4:0] level;

    int vecs = 0;
    int miscompares = 0;
    logic cap_txd  [0:399];
    logic cap_loop [0:399];
    logic cap_temt [0:399];
    bit   cap_to;

    always #5 clk = ~clk;

    uart_tx_engine dut (
        .apb_clk_in(clk), .apb_rstn_in(rstn), .bclk_tick_in(tick),
        .thr_wr_in(wr), .thr_data_in(wdat), .fifo_en_in(fifo_en),
        .txclr_in(txclr), .utrst_in(utrst), .wls_in(wls), .stb_in(stb),
        .pen_in(pen), .eps_in(eps), .sp_in(sp), .bc_in(bc),
        .osm_sel_in(osm), .loop_in(loop), .txd_out(txd),
        .loop_txd_out(loop_txd), .thre_out(thre), .temt_out(temt),
        .fifo_level_out(level), .tx_ovf_out(ovf)
    );

    // Called at a falling edge; returns on the next falling edge.
    task automatic wr_byte(input logic [7:0] d);
        wr = 1'b1;
        wdat = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    // cap_*[i] holds the outputs i falling edges after the start bit was seen (or after the call).
    task automatic capture(input bit sel_loop, input int n, input bit wait_start);
        cap_to = 1'b0;
        if (wait_start) begin
            cap_to = 1'b1;
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                if ((sel_loop ? loop_txd : txd) === 1'b0) begin
                    cap_to = 1'b0;
                    break;
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            cap_txd[i]  = txd;
            cap_loop[i] = loop_txd;
            cap_temt[i] = temt;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        vecs++; if (txd !== 1'b1)      begin miscompares++; $display("FAIL reset_txd: got %b want 1", txd); end
        vecs++; if (loop_txd !== 1'b1) begin miscompares++; $display("FAIL reset_loop: got %b want 1", loop_txd); end
        vecs++; if (thre !== 1'b1)     begin miscompares++; $display("FAIL reset_thre: got %b want 1", thre); end
        vecs++; if (temt !== 1'b1)     begin miscompares++; $display("FAIL reset_temt: got %b want 1", temt); end
        vecs++; if (level !== 5'd0)    begin miscompares++; $display("FAIL reset_level: got %0d want 0", level); end
        vecs++; if (ovf !== 1'b0)      begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_8n1();
        bit exp_b [10];
        int bad;
        exp_b = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        wr_byte(8'hA5);
        vecs++; if (level !== 5'd1 || thre !== 1'b0) begin
            miscompares++; $display("FAIL 8n1_queued: got level=%0d thre=%b want 1,0", level, thre); end
        capture(1'b0, 162, 1'b1);
        vecs++; if (cap_to !== 1'b0) begin miscompares++; $display("FAIL 8n1_start: got timeout want start bit"); end
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int k = 0; k < 16; k++) if (cap_txd[b*16+k] !== exp_b[b]) bad++;
            vecs++;
            if (bad != 0) begin miscompares++;
                $display("FAIL 8n1_bit%0d: got %b (%0d/16 samples off) want %b", b, cap_txd[b*16+8], bad, exp_b[b]); end
        end
        bad = 0;
        for (int i = 0; i < 162; i++) if (cap_loop[i] !== 1'b1) bad++;
        vecs++; if (bad != 0) begin miscompares++; $display("FAIL 8n1_loop_idle: got %0d low samples want 0", bad); end
        vecs++; if (cap_temt[159] !== 1'b0 || cap_temt[160] !== 1'b1) begin miscompares++;
            $display("FAIL 8n1_temt: got %b%b at stop end want 01", cap_temt[159], cap_temt[160]); end
    endtask

    task automatic test_parity();
        bit   exp_b [2][10];
        logic [7:0] dat [2];
        int bad;
        exp_b[0] = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 1};
        exp_b[1] = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 1};
        dat = '{8'h35, 8'h34};
        wls = 2'b10; pen = 1'b1; eps = 1'b1;
        for (int c = 0; c < 2; c++) begin
            sp = (c == 1);
            wr_byte(dat[c]);
            capture(1'b0, 162, 1'b1);
            vecs++; if (cap_to !== 1'b0) begin miscompares++; $display("FAIL par%0d_start: got timeout want start bit", c); end
            for (int b = 0; b < 10; b++) begin
                bad = 0;
                for (int k = 0; k < 16; k++) if (cap_txd[b*16+k] !== exp_b[c][b]) bad++;
                vecs++;
                if (bad != 0) begin miscompares++;
                    $display("FAIL par%0d_bit%0d: got %b (%0d/16 off) want %b", c, b, cap_txd[b*16+8], bad, exp_b[c][b]); end
            end
        end
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    endtask

    task automatic test_overflow();
        bit exp_b [10];
        int ovf_cnt, ovf_at, bad;
        exp_b = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
        tick = 1'b0; ovf_cnt = 0; ovf_at = -1;
        for (int i = 0; i < 18; i++) begin
            wr = 1'b1; wdat = 8'h40 + 8'(i);
            @(negedge clk);
            if (ovf === 1'b1) begin ovf_cnt++; ovf_at = i; end
        end
        wr = 1'b0;
        repeat (3) begin @(negedge clk); if (ovf === 1'b1) ovf_cnt++; end
        vecs++; if (ovf_cnt != 1 || ovf_at != 17) begin miscompares++;
            $display("FAIL ovf_pulse: got %0d pulses at write %0d want 1 at 17", ovf_cnt, ovf_at); end
        vecs++; if (level !== 5'd16) begin miscompares++; $display("FAIL ovf_level: got %0d want 16", level); end
        vecs++; if (thre !== 1'b0 || temt !== 1'b0) begin miscompares++;
            $display("FAIL ovf_status: got thre=%b temt=%b want 0,0", thre, temt); end
        txclr = 1'b1; wr = 1'b1; wdat = 8'h99;
        @(negedge clk);
        txclr = 1'b0; wr = 1'b0;
        vecs++; if (level !== 5'd0 || ovf !== 1'b0) begin miscompares++;
            $display("FAIL clr_level: got level=%0d ovf=%b want 0,0", level, ovf); end
        vecs++; if (thre !== 1'b1 || temt !== 1'b0) begin miscompares++;
            $display("FAIL clr_status: got thre=%b temt=%b want 1,0", thre, temt); end
        @(negedge clk);
        vecs++; if (level !== 5'd0) begin miscompares++; $display("FAIL clr_drop: got level %0d want 0", level); end
        tick = 1'b1;
        capture(1'b0, 162, 1'b0);
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int k = 0; k < 16; k++) if (cap_txd[b*16+k] !== exp_b[b]) bad++;
            vecs++;
            if (bad != 0) begin miscompares++;
                $display("FAIL clr_frame_bit%0d: got %b (%0d/16 off) want %b", b, cap_txd[b*16+8], bad, exp_b[b]); end
        end
        vecs++; if (cap_temt[159] !== 1'b0 || cap_temt[160] !== 1'b1) begin miscompares++;
            $display("FAIL clr_temt: got %b%b want 01", cap_temt[159], cap_temt[160]); end
    endtask

    task automatic test_stop15_holding();
        bit exp_b [6];
        int bad;
        exp_b = '{0, 1, 0, 1, 0, 1};
        wls = 2'b00; stb = 1'b1; osm = 1'b1;
        wr_byte(8'hF5);
        capture(1'b0, 99, 1'b1);
        vecs++; if (cap_to !== 1'b0) begin miscompares++; $display("FAIL s15_start: got timeout want start bit"); end
        for (int b = 0; b < 6; b++) begin
            bad = 0;
            for (int k = 0; k < 13; k++) if (cap_txd[b*13+k] !== exp_b[b]) bad++;
            vecs++;
            if (bad != 0) begin miscompares++;
                $display("FAIL s15_bit%0d: got %b (%0d/13 off) want %b", b, cap_txd[b*13+6], bad, exp_b[b]); end
        end
        bad = 0;
        for (int i = 78; i < 99; i++) if (cap_txd[i] !== 1'b1) bad++;
        vecs++; if (bad != 0) begin miscompares++; $display("FAIL s15_stop: got %0d low samples want 0", bad); end
        vecs++; if (cap_temt[96] !== 1'b0 || cap_temt[97] !== 1'b1) begin miscompares++;
            $display("FAIL s15_len: got temt %b%b at tick 19/20 want 01", cap_temt[96], cap_temt[97]); end
        wls = 2'b11; stb = 1'b0; osm = 1'b0;

        fifo_en = 1'b0; tick = 1'b0;
        repeat (2) @(negedge clk);
        wr_byte(8'h11);
        repeat (2) @(negedge clk);
        vecs++; if (level !== 5'd0 || thre !== 1'b1 || temt !== 1'b0) begin miscompares++;
            $display("FAIL hold_first: got level=%0d thre=%b temt=%b want 0,1,0", level, thre, temt); end
        wr_byte(8'h22);
        vecs++; if (level !== 5'd1 || thre !== 1'b0 || ovf !== 1'b0) begin miscompares++;
            $display("FAIL hold_second: got level=%0d thre=%b ovf=%b want 1,0,0", level, thre, ovf); end
        wr_byte(8'h33);
        vecs++; if (ovf !== 1'b1 || level !== 5'd1) begin miscompares++;
            $display("FAIL hold_ovf: got ovf=%b level=%0d want 1,1", ovf, level); end
        @(negedge clk);
        vecs++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL hold_ovf_pulse: got %b want 0", ovf); end

        utrst = 1'b0;
        @(negedge clk);
        vecs++; if (txd !== 1'b1 || level !== 5'd0 || thre !== 1'b1 || temt !== 1'b1) begin miscompares++;
            $display("FAIL utrst: got txd=%b level=%0d thre=%b temt=%b want 1,0,1,1", txd, level, thre, temt); end
        wr_byte(8'h44);
        vecs++; if (level !== 5'd0 || ovf !== 1'b0) begin miscompares++;
            $display("FAIL utrst_wr: got level=%0d ovf=%b want 0,0", level, ovf); end
        utrst = 1'b1;
        repeat (3) @(negedge clk);
        vecs++; if (txd !== 1'b1 || temt !== 1'b1) begin miscompares++;
            $display("FAIL utrst_release: got txd=%b temt=%b want 1,1", txd, temt); end
        fifo_en = 1'b1; tick = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        wr_byte(8'h81);
        wr_byte(8'h55);
        repeat (38) @(negedge clk);
        vecs++; if (txd !== 1'b0 || level !== 5'd1 || temt !== 1'b0) begin miscompares++;
            $display("FAIL rstmid_pre: got txd=%b level=%0d temt=%b want 0,1,0", txd, level, temt); end
        rstn = 1'b0;
        #1;
        vecs++; if (txd !== 1'b1 || level !== 5'd0 || thre !== 1'b1 || temt !== 1'b1) begin miscompares++;
            $display("FAIL rstmid: got txd=%b level=%0d thre=%b temt=%b want 1,0,1,1", txd, level, thre, temt); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        vecs++; if (txd !== 1'b1 || level !== 5'd0) begin miscompares++;
            $display("FAIL rstmid_after: got txd=%b level=%0d want 1,0", txd, level); end
    endtask

    task automatic test_break_loop();
        bit   exp_b [10];
        bit   exp_l [10];
        logic want;
        int   bad;
        exp_b = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 1};
        exp_l = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
        wr_byte(8'hE7);
        fork
            capture(1'b0, 162, 1'b1);
            begin
                repeat (40) @(negedge clk);
                bc = 1'b1;
                repeat (24) @(negedge clk);
                bc = 1'b0;
            end
        join
        vecs++; if (cap_to !== 1'b0) begin miscompares++; $display("FAIL brk_start: got timeout want start bit"); end
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int k = 0; k < 16; k++) begin
                want = (b*16+k >= 40 && b*16+k < 64) ? 1'b0 : exp_b[b];
                if (cap_txd[b*16+k] !== want) bad++;
            end
            vecs++;
            if (bad != 0) begin miscompares++;
                $display("FAIL brk_bit%0d: got %0d/16 samples off want %b outside break", b, bad, exp_b[b]); end
        end
        vecs++; if (cap_temt[159] !== 1'b0 || cap_temt[160] !== 1'b1) begin miscompares++;
            $display("FAIL brk_temt: got %b%b want 01", cap_temt[159], cap_temt[160]); end

        loop = 1'b1;
        wr_byte(8'h3C);
        capture(1'b1, 162, 1'b1);
        vecs++; if (cap_to !== 1'b0) begin miscompares++; $display("FAIL loop_start: got timeout want start bit"); end
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int k = 0; k < 16; k++) if (cap_loop[b*16+k] !== exp_l[b]) bad++;
            vecs++;
            if (bad != 0) begin miscompares++;
                $display("FAIL loop_bit%0d: got %b (%0d/16 off) want %b", b, cap_loop[b*16+8], bad, exp_l[b]); end
        end
        bad = 0;
        for (int i = 0; i < 162; i++) if (cap_txd[i] !== 1'b1) bad++;
        vecs++; if (bad != 0) begin miscompares++; $display("FAIL loop_pin_idle: got %0d low samples want 0", bad); end
        loop = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; tick = 1'b1; wr = 1'b0; wdat = 8'h00; fifo_en = 1'b1;
        txclr = 1'b0; utrst = 1'b1; wls = 2'b11; stb = 1'b0; pen = 1'b0;
        eps = 1'b0; sp = 1'b0; bc = 1'b0; osm = 1'b0; loop = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_overflow();
        test_stop15_holding();
        test_reset_mid();
        test_break_loop();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion within 1 ms want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
